inst_fetch: RTL

Instruction-fetch stage of the five-stage RV32I pipeline, directly upstream of the IF_ID register and the decode stage. It holds the PC and looks up a direct-mapped instruction cache. On a miss it fetches the instruction word from MEMCTRL through a request/done handshake. It delivers `(pc, inst, predicted next pc)` to IF_ID and redirects on JAL jumps from ID and branch/JALR corrections from EX.

---
 rtl/inst_fetch_pkg.sv | 31 +++
 rtl/inst_fetch_icache.sv | 57 +++++
 rtl/inst_fetch.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/inst_fetch_pkg.sv
// ============================================================================
// Module   : inst_fetch_pkg
// Purpose  : Shared widths, constants and FSM encoding for the fetch stage.
// Revision : 1.0
// ============================================================================
`default_nettype none

package inst_fetch_pkg;

  localparam int AddrLen = 32;
  localparam int InstLen = 32;

  localparam logic Enable  = 1'b1;
  localparam logic Disable = 1'b0;
  localparam logic True    = 1'b1;
  localparam logic False   = 1'b0;

  localparam logic [InstLen-1:0] ZERO_WORD = 32'h0000_0000;

  localparam logic [1:0] IF_IDLE    = 2'd0;
  localparam logic [1:0] IF_FETCH   = 2'd1;
  localparam logic [1:0] IF_DISCARD = 2'd2;

  // Redirect targets are forced onto a word boundary.
  function automatic logic [AddrLen-1:0] align_word(input logic [AddrLen-1:0] addr);
    return addr & ~32'd3;
  endfunction

endpackage

`default_nettype wire

// File: rtl/inst_fetch_icache.sv
// ============================================================================
// Module   : inst_fetch_icache
// Purpose  : Direct-mapped one-word-per-line instruction cache, async lookup.
// Revision : 1.0
// ============================================================================
`default_nettype none

module inst_fetch_icache
  import inst_fetch_pkg::*;
#(
  parameter int ENTRIES = 64
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic [AddrLen-1:2] raddr_i,
  output logic               hit_o,
  output logic [InstLen-1:0] data_o,
  input  logic               we_i,
  input  logic [AddrLen-1:2] waddr_i,
  input  logic [InstLen-1:0] wdata_i
);

  localparam int IDX  = $clog2(ENTRIES);
  localparam int TAGW = AddrLen - IDX - 2;

  logic [ENTRIES-1:0] valid_q;
  logic [TAGW-1:0]    tag_q  [ENTRIES];
  logic [InstLen-1:0] data_q [ENTRIES];

  logic [IDX-1:0] ridx;
  logic [IDX-1:0] widx;

  assign ridx = raddr_i[IDX+1:2];
  assign widx = waddr_i[IDX+1:2];

  assign hit_o  = valid_q[ridx] && (tag_q[ridx] == raddr_i[AddrLen-1:IDX+2]);
  assign data_o = data_q[ridx];

  // Only the valid bits need clearing; stale tag/data are masked by them.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      valid_q <= '0;
    end else if (we_i) begin
      valid_q[widx] <= True;
    end
  end

  always_ff @(posedge clk_in) begin
    if (we_i) begin
      tag_q[widx]  <= waddr_i[AddrLen-1:IDX+2];
      data_q[widx] <= wdata_i;
    end
  end

endmodule

`default_nettype wire

// File: rtl/inst_fetch.sv
// ============================================================================
// Module   : inst_fetch
// Purpose  : RV32I fetch stage: PC, icache lookup, MEMCTRL refill, redirects.
// Revision : 1.0
// ============================================================================
`default_nettype none

module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int                 ICACHE_ENTRIES = 64,
  parameter logic [AddrLen-1:0] RESET_PC       = 32'h0
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               rdy_in,
  input  logic               stall_i,
  input  logic               id_jump_enable_i,
  input  logic [AddrLen-1:0] id_jump_pc_i,
  input  logic               ex_branch_enable_i,
  input  logic [AddrLen-1:0] ex_branch_pc_i,
  output logic               mem_req_o,
  output logic [AddrLen-1:0] mem_addr_o,
  input  logic               mem_done_i,
  input  logic [InstLen-1:0] mem_inst_i,
  output logic               valid_o,
  output logic [AddrLen-1:0] pc_o,
  output logic [InstLen-1:0] inst_o,
  output logic [AddrLen-1:0] predicted_pc_o
);

  logic [1:0]         state_q, state_d;
  logic [AddrLen-1:0] pc_q, pc_d;
  logic               valid_q, valid_d;
  logic [AddrLen-1:0] pc_out_q, pc_out_d;
  logic [InstLen-1:0] inst_q, inst_d;
  logic               req_q, req_d;
  logic [AddrLen-1:0] addr_q, addr_d;

  logic               cache_hit;
  logic [InstLen-1:0] cache_data;
  logic               fill_we;
  logic               redirect;
  logic [AddrLen-1:0] redirect_pc;
  logic               done;

  inst_fetch_icache #(
    .ENTRIES (ICACHE_ENTRIES)
  ) u_icache (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .raddr_i (pc_q[AddrLen-1:2]),
    .hit_o   (cache_hit),
    .data_o  (cache_data),
    .we_i    (fill_we),
    .waddr_i (addr_q[AddrLen-1:2]),
    .wdata_i (mem_inst_i)
  );

  assign redirect    = ex_branch_enable_i | id_jump_enable_i;
  assign redirect_pc = align_word(ex_branch_enable_i ? ex_branch_pc_i : id_jump_pc_i);
  assign done        = mem_done_i && (state_q != IF_IDLE);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    valid_d  = valid_q;
    pc_out_d = pc_out_q;
    inst_d   = inst_q;
    req_d    = req_q;
    addr_d   = addr_q;
    fill_we  = Disable;

    if (rdy_in) begin
      // A completing request always retires, whatever else happens this cycle.
      if (done) begin
        fill_we = Enable;
        req_d   = Disable;
        state_d = IF_IDLE;
      end

      if (redirect) begin
        pc_d    = redirect_pc;
        valid_d = False;
        if (state_q == IF_FETCH && !done) begin
          state_d = IF_DISCARD;
        end
      end else if (!stall_i) begin
        case (state_q)
          IF_IDLE: begin
            if (cache_hit) begin
              pc_out_d = pc_q;
              inst_d   = cache_data;
              valid_d  = True;
              pc_d     = pc_q + 32'd4;
            end else begin
              valid_d = False;
              req_d   = Enable;
              addr_d  = pc_q;
              state_d = IF_FETCH;
            end
          end
          IF_FETCH: begin
            if (done) begin
              pc_out_d = pc_q;
              inst_d   = mem_inst_i;
              valid_d  = True;
              pc_d     = pc_q + 32'd4;
            end else begin
              valid_d = False;
            end
          end
          IF_DISCARD: valid_d = False;
          default:    state_d = IF_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q  <= IF_IDLE;
      pc_q     <= RESET_PC;
      valid_q  <= False;
      pc_out_q <= ZERO_WORD;
      inst_q   <= ZERO_WORD;
      req_q    <= Disable;
      addr_q   <= ZERO_WORD;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      valid_q  <= valid_d;
      pc_out_q <= pc_out_d;
      inst_q   <= inst_d;
      req_q    <= req_d;
      addr_q   <= addr_d;
    end
  end

  assign mem_req_o      = req_q;
  assign mem_addr_o     = addr_q;
  assign valid_o        = valid_q;
  assign pc_o           = pc_out_q;
  assign inst_o         = inst_q;
  assign predicted_pc_o = pc_out_q + 32'd4;

endmodule

`default_nettype wire
